cdb_arbiter: RTL and testbench

- Transmitter end of the common data bus (CDB) consumed by the ALU reservation station, load/store buffer and reorder buffer.
- Collects completed results from two producers: the ALU reservation-station submit port and the load/store buffer result port.
- Buffers each producer in its own FIFO and broadcasts at most one result per cycle on registered cdb_* outputs.
- Producers have no backpressure in the current core, so the block provides stall hints and a sticky overflow flag.

---
 rtl/cdb_arbiter_pkg.sv | 23 ++
 rtl/cdb_fifo.sv | 62 ++++++
 rtl/cdb_arbiter.sv | 143 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: tag width, the None tag encoding, priority encoding and
// the {addr, val, tag} bundle layout used by the arbiter and its FIFOs.
package cdb_arbiter_pkg;

  localparam int unsigned CDB_TAG_W  = 4;
  localparam int unsigned CDB_ADDR_W = 32;
  localparam int unsigned CDB_VAL_W  = 32;

  localparam logic [CDB_TAG_W-1:0] TAG_NONE = '0;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LSB = 1'b1
  } pri_e;

  // Bundle is packed {addr, val, tag}, tag in the LSBs.
  function automatic int unsigned cdb_bus_w(input int unsigned val_w, input int unsigned tag_w);
    return CDB_ADDR_W + val_w + tag_w;
  endfunction

  localparam int unsigned CDB_BUS_W = cdb_bus_w(CDB_VAL_W, CDB_TAG_W);

endpackage

// File: rtl/cdb_fifo.sv
// Per-producer result FIFO. Push into a full FIFO is ignored unless the head is
// popped in the same cycle; flush empties it and wins over push/pop.
module cdb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 68
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // When full, wr_ptr aliases rd_ptr; the old head is already consumed combinationally.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush && do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB transmitter: buffers ALU and load/store results, bypasses into an empty
// FIFO's slot, and broadcasts one result per cycle with round-robin priority.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VAL_W = CDB_VAL_W,
  parameter int unsigned TAG_W = CDB_TAG_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [VAL_W-1:0] alu_val,
  input  logic [31:0]      alu_addr,
  input  logic             lsb_valid,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [VAL_W-1:0] lsb_val,
  input  logic [31:0]      lsb_addr,
  output logic             alu_stall,
  output logic             lsb_stall,
  output logic             cdb_active,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [VAL_W-1:0] cdb_val,
  output logic [31:0]      cdb_addr,
  output logic             overflow_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = cdb_bus_w(VAL_W, TAG_W);
  localparam logic [TAG_W-1:0] TAG_IDLE = TAG_W'(TAG_NONE);
  localparam logic [BW-1:0] IDLE_BUS = {{(CDB_ADDR_W + VAL_W){1'b0}}, TAG_IDLE};
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

  logic [BW-1:0] alu_in_bus, lsb_in_bus;
  logic [BW-1:0] alu_head, lsb_head;
  logic          alu_empty, lsb_empty;
  logic          alu_full, lsb_full;
  logic [CW-1:0] alu_count, lsb_count;

  logic          alu_cand, lsb_cand;
  logic [BW-1:0] alu_sel, lsb_sel, win_bus;
  logic          grant_alu, grant_lsb;
  logic          alu_push, alu_pop, lsb_push, lsb_pop;
  logic          ovf_set;
  pri_e          pri_q, pri_d;

  logic [BW-1:0] cdb_q;
  logic          active_q;
  logic          ovf_q;

  assign alu_in_bus = {alu_addr, alu_val, alu_tag};
  assign lsb_in_bus = {lsb_addr, lsb_val, lsb_tag};

  cdb_fifo #(.DEPTH(DEPTH), .W(BW)) u_alu_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .push    (alu_push),
    .pop     (alu_pop),
    .flush   (flush_in),
    .wr_data (alu_in_bus),
    .head    (alu_head),
    .empty   (alu_empty),
    .full    (alu_full),
    .count   (alu_count)
  );

  cdb_fifo #(.DEPTH(DEPTH), .W(BW)) u_lsb_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .push    (lsb_push),
    .pop     (lsb_pop),
    .flush   (flush_in),
    .wr_data (lsb_in_bus),
    .head    (lsb_head),
    .empty   (lsb_empty),
    .full    (lsb_full),
    .count   (lsb_count)
  );

  always_comb begin
    alu_cand  = !alu_empty || alu_valid;
    lsb_cand  = !lsb_empty || lsb_valid;
    alu_sel   = alu_empty ? alu_in_bus : alu_head;
    lsb_sel   = lsb_empty ? lsb_in_bus : lsb_head;

    grant_alu = alu_cand && (!lsb_cand || pri_q == PRI_ALU);
    grant_lsb = lsb_cand && !grant_alu;

    // An incoming result is pushed unless it went straight out via bypass.
    alu_pop   = grant_alu && !alu_empty;
    lsb_pop   = grant_lsb && !lsb_empty;
    alu_push  = alu_valid && !(grant_alu && alu_empty);
    lsb_push  = lsb_valid && !(grant_lsb && lsb_empty);

    ovf_set   = (alu_push && alu_full && !alu_pop) ||
                (lsb_push && lsb_full && !lsb_pop);

    pri_d = pri_q;
    if (grant_alu)      pri_d = PRI_LSB;
    else if (grant_lsb) pri_d = PRI_ALU;

    if (flush_in) begin
      grant_alu = 1'b0;
      grant_lsb = 1'b0;
      alu_push  = 1'b0;
      alu_pop   = 1'b0;
      lsb_push  = 1'b0;
      lsb_pop   = 1'b0;
      ovf_set   = 1'b0;
      pri_d     = PRI_ALU;
    end

    win_bus = IDLE_BUS;
    if (grant_alu)      win_bus = alu_sel;
    else if (grant_lsb) win_bus = lsb_sel;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pri_q    <= PRI_ALU;
      active_q <= 1'b0;
      cdb_q    <= IDLE_BUS;
      ovf_q    <= 1'b0;
    end else if (rdy_in) begin
      pri_q    <= pri_d;
      active_q <= grant_alu || grant_lsb;
      cdb_q    <= win_bus;
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  assign {cdb_addr, cdb_val, cdb_tag} = cdb_q;
  assign cdb_active   = active_q;
  assign overflow_err = ovf_q;
  assign alu_stall    = (alu_count >= STALL_CNT);
  assign lsb_stall    = (lsb_count >= STALL_CNT);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: bypass latency, alternation, fill/overflow,
// flush, pause and asynchronous reset, all with hand-computed expectations.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        alu_valid;
  logic [3:0]  alu_tag;
  logic [31:0] alu_val;
  logic [31:0] alu_addr;
  logic        lsb_valid;
  logic [3:0]  lsb_tag;
  logic [31:0] lsb_val;
  logic [31:0] lsb_addr;
  logic        alu_stall;
  logic        lsb_stall;
  logic        cdb_active;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic [31:0] cdb_addr;
  logic        overflow_err;

  int n_cmp = 0;
  int n_err = 0;

  cdb_arbiter #(.DEPTH(4), .VAL_W(32), .TAG_W(4)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .flush_in     (flush_in),
    .alu_valid    (alu_valid),
    .alu_tag      (alu_tag),
    .alu_val      (alu_val),
    .alu_addr     (alu_addr),
    .lsb_valid    (lsb_valid),
    .lsb_tag      (lsb_tag),
    .lsb_val      (lsb_val),
    .lsb_addr     (lsb_addr),
    .alu_stall    (alu_stall),
    .lsb_stall    (lsb_stall),
    .cdb_active   (cdb_active),
    .cdb_tag      (cdb_tag),
    .cdb_val      (cdb_val),
    .cdb_addr     (cdb_addr),
    .overflow_err (overflow_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic chk_cdb(input string name, input logic act, input logic [3:0] tag,
                         input logic [31:0] val, input logic [31:0] addr);
    chk(name, {3'b0, cdb_active, cdb_tag, cdb_val, cdb_addr}, {3'b0, act, tag, val, addr});
  endtask

  task automatic chk_idle(input string name);
    chk_cdb(name, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic alu_in(input logic [3:0] t, input logic [31:0] v, input logic [31:0] a);
    alu_valid = 1'b1; alu_tag = t; alu_val = v; alu_addr = a;
  endtask

  task automatic lsb_in(input logic [3:0] t, input logic [31:0] v, input logic [31:0] a);
    lsb_valid = 1'b1; lsb_tag = t; lsb_val = v; lsb_addr = a;
  endtask

  task automatic idle_in();
    alu_valid = 1'b0; alu_tag = '0; alu_val = '0; alu_addr = '0;
    lsb_valid = 1'b0; lsb_tag = '0; lsb_val = '0; lsb_addr = '0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    idle_in();
    tick(); tick();
    chk_idle("reset_cdb");
    chk("reset_flags", {69'd0, overflow_err, alu_stall, lsb_stall}, 72'd0);
    rst_in = 1'b0;

    // single ALU submit: one-cycle latency, one active cycle
    tick(); tick(); tick();
    alu_in(4'd1, 32'h12, 32'h100);
    tick();
    chk_cdb("t1_bypass", 1'b1, 4'd1, 32'h12, 32'h100);
    idle_in();
    tick();
    chk_idle("t1_after");

    // flush returns priority to ALU
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    chk_idle("flush_idle");

    // simultaneous submits alternate ALU/LSB
    for (int i = 1; i <= 3; i++) begin
      alu_in(4'd1, 32'hA0 + i, 32'h1A0 + i);
      lsb_in(4'd4, 32'hB0 + i, 32'h1B0 + i);
      tick();
      if (i == 1) chk_cdb("t2_c1", 1'b1, 4'd1, 32'hA1, 32'h1A1);
      if (i == 2) chk_cdb("t2_c2", 1'b1, 4'd4, 32'hB1, 32'h1B1);
      if (i == 3) chk_cdb("t2_c3", 1'b1, 4'd1, 32'hA2, 32'h1A2);
    end
    idle_in();
    tick(); chk_cdb("t2_c4", 1'b1, 4'd4, 32'hB2, 32'h1B2);
    tick(); chk_cdb("t2_c5", 1'b1, 4'd1, 32'hA3, 32'h1A3);
    tick(); chk_cdb("t2_c6", 1'b1, 4'd4, 32'hB3, 32'h1B3);
    tick(); chk_idle("t2_c7");

    // one ALU grant leaves priority on LSB for the fill test
    alu_in(4'd1, 32'h77, 32'h770);
    tick();
    chk_cdb("t3_setup", 1'b1, 4'd1, 32'h77, 32'h770);

    // both producers every cycle: ALU fills first and drops its 9th result
    for (int i = 1; i <= 9; i++) begin
      alu_in(4'd1, 32'h30 + i, 32'h300 + i);
      lsb_in(4'd4, 32'h40 + i, 32'h400 + i);
      tick();
      if (i % 2 == 1)
        chk_cdb("t3_lsb_out", 1'b1, 4'd4, 32'h40 + (i + 1) / 2, 32'h400 + (i + 1) / 2);
      else
        chk_cdb("t3_alu_out", 1'b1, 4'd1, 32'h30 + i / 2, 32'h300 + i / 2);
      if (i == 4) chk("t3_alu_stall_c2", {71'd0, alu_stall}, 72'd0);
      if (i == 5) chk("t3_alu_stall_c3", {71'd0, alu_stall}, 72'd1);
      if (i == 5) chk("t3_lsb_stall_c2", {71'd0, lsb_stall}, 72'd0);
      if (i == 6) chk("t3_lsb_stall_c3", {71'd0, lsb_stall}, 72'd1);
      if (i == 8) chk("t3_no_ovf_full_pop", {71'd0, overflow_err}, 72'd0);
      if (i == 9) chk("t3_ovf", {71'd0, overflow_err}, 72'd1);
    end
    idle_in();
    tick();
    chk_cdb("t3_drain_x5", 1'b1, 4'd1, 32'h35, 32'h305);
    chk("t4_pre_stalls", {70'd0, alu_stall, lsb_stall}, 72'd3);

    // flush with ALU holding 3 and an LSB submit in flight
    flush_in = 1'b1;
    lsb_in(4'd4, 32'hEE, 32'hEE0);
    tick();
    flush_in = 1'b0;
    idle_in();
    chk_idle("t4_flush_out");
    chk("t4_post_flags", {69'd0, overflow_err, alu_stall, lsb_stall}, 72'd4);
    alu_in(4'd1, 32'h51, 32'h510);
    lsb_in(4'd4, 32'h52, 32'h520);
    tick();
    chk_cdb("t4_alu_first", 1'b1, 4'd1, 32'h51, 32'h510);
    idle_in();
    tick();
    chk_cdb("t4_lsb_next", 1'b1, 4'd4, 32'h52, 32'h520);
    tick();
    chk_idle("t4_empty");

    // pause holds the broadcast and ignores submits
    alu_in(4'd2, 32'h22, 32'h220);
    lsb_in(4'd5, 32'h55, 32'h550);
    tick();
    chk_cdb("t5_active", 1'b1, 4'd2, 32'h22, 32'h220);
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        alu_in(4'd3, 32'h33, 32'h330);
        lsb_in(4'd6, 32'h66, 32'h660);
      end else begin
        idle_in();
      end
      tick();
      chk_cdb("t5_frozen", 1'b1, 4'd2, 32'h22, 32'h220);
    end
    rdy_in = 1'b1;
    idle_in();
    tick();
    chk_cdb("t5_resume", 1'b1, 4'd5, 32'h55, 32'h550);
    tick();
    chk_idle("t5_idle1");
    tick();
    chk_idle("t5_idle2");

    // asynchronous reset mid-broadcast
    alu_in(4'd7, 32'h77, 32'h771);
    tick();
    chk_cdb("t6_active", 1'b1, 4'd7, 32'h77, 32'h771);
    idle_in();
    #3 rst_in = 1'b1;
    #1;
    chk_idle("t6_async_cdb");
    chk("t6_async_ovf", {71'd0, overflow_err}, 72'd0);
    #1 rst_in = 1'b0;
    tick();
    chk_idle("t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
